// File: rtl/waveform_pkg.sv
// Shared types and constants for the waveform capture path (capture stage and UART framer).
// SYNCx are the two fixed frame-start bytes; DEF_* are the default build geometry.
package waveform_pkg;

    localparam int DEF_NUM_SAMPLES = 2000;
    localparam int DEF_SAMPLE_W    = 14;
    localparam int DEF_ADDR_W      = 11;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_SEND_HI,
        ST_SEND_LO,
        ST_CSUM
    } state_t;

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] wn);
        case (idx)
            2'd0:    hdr_byte = SYNC0;
            2'd1:    hdr_byte = SYNC1;
            2'd2:    hdr_byte = wn[15:8];
            default: hdr_byte = wn[7:0];
        endcase
    endfunction

endpackage

// File: rtl/waveform_uart_framer.sv
// Streams each newly completed capture as an A5 5A wn_hi wn_lo {hi,lo}* byte frame to the UART TX.
// Defining WAVEFORM_FRAMER_CHECKSUM_EN appends one XOR checksum byte covering everything after 0x5A.
// Latency: A5 is valid two edges after the capture edge; tx_data/tx_valid are held while tx_ready is low.
module waveform_uart_framer
    import waveform_pkg::*;
#(
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [15:0]         wave_number,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [SAMPLE_W-1:0] rd_data,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic [7:0]          dropped
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SAMPLES - 1);

    state_t            state_q, state_d;
    logic [15:0]       wn_prev_q;
    logic [15:0]       wn_lat_q, wn_lat_d;
    logic [1:0]        hdr_idx_q, hdr_idx_d;
    logic              phase_q, phase_d;
    logic [7:0]        lo_q, lo_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic [7:0]        dropped_q, dropped_d;
`ifdef WAVEFORM_FRAMER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic        new_cap;
    logic [15:0] sample16;
    logic [7:0]  samp_hi;
    logic [7:0]  samp_lo;

    assign new_cap  = (wave_number != wn_prev_q);
    assign sample16 = 16'(rd_data);
    // Top two bits of the hi byte are always zero on the wire, whatever SAMPLE_W is.
    assign samp_hi  = sample16[15:8] & 8'h3F;
    assign samp_lo  = sample16[7:0];

    always_comb begin
        state_d    = state_q;
        wn_lat_d   = wn_lat_q;
        hdr_idx_d  = hdr_idx_q;
        phase_d    = phase_q;
        lo_d       = lo_q;
        rd_addr_d  = rd_addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        dropped_d  = dropped_q;
`ifdef WAVEFORM_FRAMER_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        if (new_cap && (state_q != ST_IDLE) && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (new_cap) begin
                    wn_lat_d  = wave_number;
                    hdr_idx_d = 2'd0;
                    busy_d    = 1'b1;
                    state_d   = ST_HDR;
`ifdef WAVEFORM_FRAMER_CHECKSUM_EN
                    csum_d    = wave_number[15:8] ^ wave_number[7:0];
`endif
                end
            end
            ST_HDR: begin
                if (!tx_valid_q) begin
                    tx_data_d  = hdr_byte(hdr_idx_q, wn_lat_q);
                    tx_valid_d = 1'b1;
                end else if (tx_ready) begin
                    if (hdr_idx_q == 2'd3) begin
                        tx_valid_d = 1'b0;
                        rd_addr_d  = '0;
                        phase_d    = 1'b0;
                        state_d    = ST_FETCH;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                        tx_data_d = hdr_byte(hdr_idx_q + 2'd1, wn_lat_q);
                    end
                end
            end
            ST_FETCH: begin
                // phase 0 presents the address, phase 1 sees the RAM output
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    tx_data_d  = samp_hi;
                    tx_valid_d = 1'b1;
                    lo_d       = samp_lo;
                    state_d    = ST_SEND_HI;
`ifdef WAVEFORM_FRAMER_CHECKSUM_EN
                    csum_d     = csum_q ^ samp_hi ^ samp_lo;
`endif
                end
            end
            ST_SEND_HI: begin
                if (tx_ready) begin
                    tx_data_d = lo_q;
                    state_d   = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                if (tx_ready) begin
                    if (rd_addr_q == LAST_IDX) begin
`ifdef WAVEFORM_FRAMER_CHECKSUM_EN
                        tx_data_d  = csum_q;
                        state_d    = ST_CSUM;
`else
                        tx_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        state_d    = ST_IDLE;
`endif
                    end else begin
                        tx_valid_d = 1'b0;
                        rd_addr_d  = rd_addr_q + ADDR_W'(1);
                        phase_d    = 1'b0;
                        state_d    = ST_FETCH;
                    end
                end
            end
`ifdef WAVEFORM_FRAMER_CHECKSUM_EN
            ST_CSUM: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wn_prev_q  <= '0;
            wn_lat_q   <= '0;
            hdr_idx_q  <= '0;
            phase_q    <= 1'b0;
            lo_q       <= '0;
            rd_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            dropped_q  <= '0;
`ifdef WAVEFORM_FRAMER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wn_prev_q  <= wave_number;
            wn_lat_q   <= wn_lat_d;
            hdr_idx_q  <= hdr_idx_d;
            phase_q    <= phase_d;
            lo_q       <= lo_d;
            rd_addr_q  <= rd_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            dropped_q  <= dropped_d;
`ifdef WAVEFORM_FRAMER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign rd_addr  = rd_addr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_waveform_uart_framer.sv
// Scoreboard bench for waveform_uart_framer: expected frames are queued at stimulus time,
// a negedge monitor pops and compares every transferred byte and checks hold-under-stall.
module tb_waveform_uart_framer;
    import waveform_pkg::*;

    localparam int NS = DEF_NUM_SAMPLES;
`ifdef WAVEFORM_FRAMER_CHECKSUM_EN
    localparam int FRAME_BYTES = 4 + 2 * NS + 1;
`else
    localparam int FRAME_BYTES = 4 + 2 * NS;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] wave_number;
    logic [10:0] rd_addr;
    logic [13:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  dropped;

    waveform_uart_framer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wave_number (wave_number),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .dropped     (dropped)
    );

    always #5 clk = ~clk;

    logic [13:0] mem [0:2047];
    always @(posedge clk) rd_data <= mem[rd_addr];

    logic [7:0] exp_q[$];
    logic [7:0] rx_log [0:4095];
    int         total = 0;
    int         bad   = 0;
    int         rx_cnt = 0;
    logic       stall_pend = 1'b0;
    logic [7:0] stall_dat  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_valid", {31'd0, tx_valid}, 32'd1);
                check("stall_data", {24'd0, tx_data}, {24'd0, stall_dat});
            end
            stall_pend = tx_valid && !tx_ready;
            stall_dat  = tx_data;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte actual=%0h required=none", tx_data);
                end else begin
                    check($sformatf("byte%0d", rx_cnt), {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
                if (rx_cnt < 4096) rx_log[rx_cnt] = tx_data;
                rx_cnt++;
            end
        end
    end

    task automatic push_frame(input logic [15:0] wn);
        logic [15:0] s16;
        logic [7:0]  hi, lo, cs;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(wn[15:8]);
        exp_q.push_back(wn[7:0]);
        cs = wn[15:8] ^ wn[7:0];
        for (int i = 0; i < NS; i++) begin
            s16 = {2'b00, mem[i]};
            hi  = {2'b00, s16[13:8]};
            lo  = s16[7:0];
            exp_q.push_back(hi);
            exp_q.push_back(lo);
            cs = cs ^ hi ^ lo;
        end
`ifdef WAVEFORM_FRAMER_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    // Called with the capture becoming visible at the next edge.
    task automatic expect_start();
        @(posedge clk); #1;
        check("lat_busy", {31'd0, busy}, 32'd1);
        check("lat_valid0", {31'd0, tx_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_valid1", {31'd0, tx_valid}, 32'd1);
        check("lat_a5", {24'd0, tx_data}, 32'hA5);
    endtask

    task automatic start_frame(input logic [15:0] wn);
        @(posedge clk); #1;
        rx_cnt = 0;
        wave_number = wn;
        push_frame(wn);
        expect_start();
    endtask

    task automatic wait_frame(input bit rnd, input int drop_at, input int ndrop, input logic [7:0] exp_drop);
        int left;
        bit done;
        left = ndrop;
        done = 1'b0;
        for (int c = 0; c < 40000 && !done; c++) begin
            @(posedge clk); #1;
            if (rnd) tx_ready = ($urandom_range(0, 2) != 0);
            if (left > 0 && rx_cnt >= drop_at) begin
                wave_number = wave_number + 16'd1;
                left--;
            end
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        tx_ready = 1'b1;
        check("frame_done", {31'd0, done}, 32'd1);
        check("frame_len", rx_cnt, FRAME_BYTES);
        check("end_valid", {31'd0, tx_valid}, 32'd0);
        check("end_dropped", {24'd0, dropped}, {24'd0, exp_drop});
    endtask

    initial begin
        int errs;
        logic [7:0]  x;
        logic [15:0] v;
        bit hit;

        rst_n       = 1'b0;
        wave_number = 16'h0000;
        tx_ready    = 1'b1;
        for (int i = 0; i < 2048; i++) mem[i] = 14'(i);
        mem[0] = 14'h2ABC;

        #2;
        check("rst_rd_addr", {21'd0, rd_addr}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_dropped", {24'd0, dropped}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("idle_no_capture", {31'd0, busy}, 32'd0);

        // wave 0 -> 1, always ready
        start_frame(16'h0001);
        wait_frame(1'b0, 0, 0, 8'd0);
        check("f1_b0", {24'd0, rx_log[0]}, 32'hA5);
        check("f1_b1", {24'd0, rx_log[1]}, 32'h5A);
        check("f1_b2", {24'd0, rx_log[2]}, 32'h00);
        check("f1_b3", {24'd0, rx_log[3]}, 32'h01);
        check("f1_s0_hi", {24'd0, rx_log[4]}, 32'h2A);
        check("f1_s0_lo", {24'd0, rx_log[5]}, 32'hBC);

        // ramp frame, random backpressure, three captures skipped
        mem[0] = 14'h0000;
        start_frame(16'h1234);
        wait_frame(1'b1, 500, 3, 8'd3);
        check("f2_b2", {24'd0, rx_log[2]}, 32'h12);
        check("f2_b3", {24'd0, rx_log[3]}, 32'h34);
        errs = 0;
        for (int i = 0; i < NS; i++) begin
            v = {rx_log[4 + 2 * i], rx_log[5 + 2 * i]};
            if (v != 16'(i)) errs++;
        end
        check("ramp_decode_errs", errs, 0);
`ifdef WAVEFORM_FRAMER_CHECKSUM_EN
        x = 8'h00;
        for (int k = 2; k < FRAME_BYTES - 1; k++) x = x ^ rx_log[k];
        check("csum", {24'd0, rx_log[FRAME_BYTES - 1]}, {24'd0, x});
`endif

        // 300 skipped captures saturate the counter
        start_frame(16'h2000);
        wait_frame(1'b0, 100, 300, 8'd255);

        // reset mid-frame
        start_frame(16'h4242);
        hit = 1'b0;
        for (int c = 0; c < 20000 && !hit; c++) begin
            @(posedge clk);
            if (rx_cnt >= 1000) hit = 1'b1;
        end
        check("reach_byte1000", {31'd0, hit}, 32'd1);
        #1 rst_n = 1'b0;
        wave_number = 16'hFFFF;
        #1;
        check("abort_valid", {31'd0, tx_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_dropped", {24'd0, dropped}, 32'd0);
        check("abort_rd_addr", {21'd0, rd_addr}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rx_cnt = 0;
        push_frame(16'hFFFF);
        expect_start();
        wait_frame(1'b0, 0, 0, 8'd0);
        check("ff_b2", {24'd0, rx_log[2]}, 32'hFF);
        check("ff_b3", {24'd0, rx_log[3]}, 32'hFF);

        // wrap 0xFFFF -> 0x0000
        start_frame(16'h0000);
        wait_frame(1'b0, 0, 0, 8'd0);
        check("wrap_b2", {24'd0, rx_log[2]}, 32'h00);
        check("wrap_b3", {24'd0, rx_log[3]}, 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
